// File: rtl/st_decoder.sv
`default_nettype none
// ============================================================================
// Module   : st_decoder
// Summary  : Thumb stack-class instruction decoder feeding the stack controller.
//            It holds each decoded op for the controller's sequencing length.
// Revision : 1.0  initial release
// ============================================================================
module st_decoder #(
   parameter int MULTI_CYCLES = 11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [7:0]  op_sel,
   output logic [8:0]  RL,
   output logic [2:0]  Rd0,
   output logic [2:0]  Rd1,
   output logic [15:0] offset,
   output logic        busy,
   output logic        illegal
);

   localparam logic [7:0] c_OP_NOP   = 8'h00;
   localparam logic [7:0] c_OP_PUSH  = 8'h01;
   localparam logic [7:0] c_OP_POP   = 8'h02;
   localparam logic [7:0] c_OP_ADDSP = 8'h04;
   localparam logic [7:0] c_OP_SUBSP = 8'h08;
   localparam logic [7:0] c_OP_MOVSP = 8'h10;
   localparam logic [7:0] c_OP_ADDS  = 8'h20;
   localparam logic [7:0] c_OP_LDRSP = 8'h40;
   localparam logic [7:0] c_OP_STRSP = 8'h80;

   // Loaded on accept so that cnt==0 lands on the last cycle of the hold.
   localparam logic [3:0] c_MULTI_LOAD = 4'(MULTI_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SINGLE = 2'd1,
      S_MULTI  = 2'd2
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [7:0]  op_q;
   logic [8:0]  rl_q;
   logic [2:0]  rd0_q;
   logic [2:0]  rd1_q;
   logic [15:0] off_q;
   logic        busy_q;
   logic        illegal_q;

   logic [7:0]  op_d;
   logic [8:0]  rl_d;
   logic [2:0]  rd0_d;
   logic [2:0]  rd1_d;
   logic [15:0] off_d;
   logic        illegal_d;
   logic        multi_d;
   logic        w_accept;

   assign instr_ready = (state_q != S_MULTI) || (cnt_q == 4'd0);
   assign w_accept    = instr_ready & instr_valid;

   always_comb begin
      op_d  = c_OP_NOP;
      rl_d  = 9'd0;
      rd0_d = 3'd0;
      rd1_d = 3'd0;
      off_d = 16'd0;
      if (instr[15:9] == 7'b1011_010) begin
         if (instr[8:0] != 9'd0) begin
            op_d = c_OP_PUSH;
            rl_d = instr[8:0];
         end
      end else if (instr[15:9] == 7'b1011_110) begin
         if (instr[8:0] != 9'd0) begin
            op_d = c_OP_POP;
            rl_d = instr[8:0];
         end
      end else if (instr[15:8] == 8'b1011_0000) begin
         op_d  = instr[7] ? c_OP_SUBSP : c_OP_ADDSP;
         off_d = {7'd0, instr[6:0], 2'b00};
      end else if (instr[15:3] == 13'b0100_0110_0110_1) begin
         op_d  = c_OP_MOVSP;
         rd0_d = instr[2:0];
      end else if (instr[15:11] == 5'b10101) begin
         op_d  = c_OP_ADDS;
         rd1_d = instr[10:8];
         off_d = {6'd0, instr[7:0], 2'b00};
      end else if (instr[15:11] == 5'b10011) begin
         op_d  = c_OP_LDRSP;
         rd1_d = instr[10:8];
         off_d = {6'd0, instr[7:0], 2'b00};
      end else if (instr[15:11] == 5'b10010) begin
         op_d  = c_OP_STRSP;
         rd1_d = instr[10:8];
         off_d = {6'd0, instr[7:0], 2'b00};
      end
      illegal_d = (op_d == c_OP_NOP);
      multi_d   = (op_d == c_OP_PUSH) || (op_d == c_OP_POP);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         op_q      <= c_OP_NOP;
         rl_q      <= 9'd0;
         rd0_q     <= 3'd0;
         rd1_q     <= 3'd0;
         off_q     <= 16'd0;
         busy_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else if (w_accept) begin
         op_q      <= op_d;
         rl_q      <= rl_d;
         rd0_q     <= rd0_d;
         rd1_q     <= rd1_d;
         off_q     <= off_d;
         busy_q    <= 1'b1;
         illegal_q <= illegal_d;
         if (multi_d) begin
            state_q <= S_MULTI;
            cnt_q   <= c_MULTI_LOAD;
         end else begin
            state_q <= S_SINGLE;
            cnt_q   <= 4'd0;
         end
      end else if ((state_q == S_MULTI) && (cnt_q != 4'd0)) begin
         cnt_q <= cnt_q - 4'd1;
      end else begin
         // No new op: retire to IDLE presenting NOP with every field cleared.
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         op_q      <= c_OP_NOP;
         rl_q      <= 9'd0;
         rd0_q     <= 3'd0;
         rd1_q     <= 3'd0;
         off_q     <= 16'd0;
         busy_q    <= 1'b0;
         illegal_q <= 1'b0;
      end
   end

   assign op_sel  = op_q;
   assign RL      = rl_q;
   assign Rd0     = rd0_q;
   assign Rd1     = rd1_q;
   assign offset  = off_q;
   assign busy    = busy_q;
   assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_st_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_st_decoder
// Summary  : Directed and randomized bench for st_decoder using a queue model
//            of per-cycle presentations.
// Revision : 1.0  initial release
// ============================================================================
module tb_st_decoder;

   localparam int HOLD = 11;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] instr = 16'd0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [7:0]  op_sel;
   logic [8:0]  RL;
   logic [2:0]  Rd0;
   logic [2:0]  Rd1;
   logic [15:0] offset;
   logic        busy;
   logic        illegal;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic        pres;
      logic [7:0]  op;
      logic [8:0]  rl;
      logic [2:0]  rd0;
      logic [2:0]  rd1;
      logic [15:0] off;
      logic        ill;
   } exp_t;

   // One entry per cycle the DUT is expected to present an op.
   exp_t q[$];

   st_decoder #(.MULTI_CYCLES(HOLD)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .op_sel      (op_sel),
      .RL          (RL),
      .Rd0         (Rd0),
      .Rd1         (Rd1),
      .offset      (offset),
      .busy        (busy),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   function automatic exp_t ref_decode(input logic [15:0] in);
      exp_t e;
      e = '0;
      e.pres = 1'b1;
      casez (in)
         16'b1011_010?_????_????: begin e.op = 8'h01; e.rl = in[8:0]; end
         16'b1011_110?_????_????: begin e.op = 8'h02; e.rl = in[8:0]; end
         16'b1011_0000_0???_????: begin e.op = 8'h04; e.off = {9'd0, in[6:0]} * 16'd4; end
         16'b1011_0000_1???_????: begin e.op = 8'h08; e.off = {9'd0, in[6:0]} * 16'd4; end
         16'b0100_0110_0110_1???: begin e.op = 8'h10; e.rd0 = in[2:0]; end
         16'b1010_1???_????_????: begin e.op = 8'h20; e.rd1 = in[10:8]; e.off = {8'd0, in[7:0]} * 16'd4; end
         16'b1001_1???_????_????: begin e.op = 8'h40; e.rd1 = in[10:8]; e.off = {8'd0, in[7:0]} * 16'd4; end
         16'b1001_0???_????_????: begin e.op = 8'h80; e.rd1 = in[10:8]; e.off = {8'd0, in[7:0]} * 16'd4; end
         default: e.op = 8'h00;
      endcase
      if ((e.op == 8'h01 || e.op == 8'h02) && e.rl == 9'd0) e.op = 8'h00;
      e.ill = (e.op == 8'h00);
      return e;
   endfunction

   function automatic logic [15:0] gen_instr();
      logic [31:0] r;
      logic [8:0]  rl;
      r  = $urandom;
      rl = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) rl = 9'd0;
      case ($urandom_range(0, 9))
         0: return {7'b1011_010, rl};
         1: return {7'b1011_110, rl};
         2: return {8'hB0, r[7:0]};
         3: return {13'b0100_0110_0110_1, r[2:0]};
         4: return {5'b10101, r[10:0]};
         5: return {5'b10011, r[10:0]};
         6: return {5'b10010, r[10:0]};
         default: return r[15:0];
      endcase
   endfunction

   // Check the current presentation, then drive the inputs for the next edge.
   task automatic cycle(input bit rnd, input logic v, input logic [15:0] in, output bit acc);
      exp_t e;
      bit   er;
      int   len;
      @(negedge clk);
      e  = (q.size() > 0) ? q.pop_front() : exp_t'(0);
      er = (q.size() == 0);
      chk("op_sel",  32'(op_sel),      32'(e.op));
      chk("RL",      32'(RL),          32'(e.rl));
      chk("Rd0",     32'(Rd0),         32'(e.rd0));
      chk("Rd1",     32'(Rd1),         32'(e.rd1));
      chk("offset",  32'(offset),      32'(e.off));
      chk("busy",    32'(busy),        32'(e.pres));
      chk("illegal", 32'(illegal),     32'(e.ill));
      chk("ready",   32'(instr_ready), 32'(er));
      if (rnd) begin
         if (er) begin
            v  = ($urandom_range(0, 3) != 0);
            in = gen_instr();
         end else begin
            v  = instr_valid;
            in = instr;
         end
      end
      instr       = in;
      instr_valid = v;
      acc = er && v;
      if (acc) begin
         e   = ref_decode(in);
         len = (e.op == 8'h01 || e.op == 8'h02) ? HOLD : 1;
         repeat (len) q.push_back(e);
      end
   endtask

   task automatic issue(input logic [15:0] in);
      bit acc;
      int n;
      n = 0;
      do begin
         cycle(1'b0, 1'b1, in, acc);
         n++;
      end while (!acc && n < 20);
      if (!acc) chk("issue_timeout", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) cycle(1'b0, 1'b0, 16'h0000, acc);
   endtask

   task automatic do_reset();
      instr_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_op_sel",  32'(op_sel),      32'd0);
      chk("rst_RL",      32'(RL),          32'd0);
      chk("rst_Rd0",     32'(Rd0),         32'd0);
      chk("rst_Rd1",     32'(Rd1),         32'd0);
      chk("rst_offset",  32'(offset),      32'd0);
      chk("rst_busy",    32'(busy),        32'd0);
      chk("rst_illegal", 32'(illegal),     32'd0);
      chk("rst_ready",   32'(instr_ready), 32'd1);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bit acc;
      #2;
      do_reset();
      idle(2);

      issue(16'hB5F0);
      issue(16'hBDF0);
      idle(13);

      issue(16'hB004);
      issue(16'hB084);
      issue(16'h466A);
      issue(16'hAB05);
      issue(16'h9CFF);
      issue(16'h9001);
      issue(16'h0000);
      issue(16'hB400);
      idle(2);

      issue(16'hB004);
      idle(2);
      issue(16'hB084);
      idle(2);

      issue(16'hB5F0);
      idle(5);
      do_reset();
      idle(1);
      issue(16'hAB05);
      idle(2);

      repeat (3000) cycle(1'b1, 1'b0, 16'h0000, acc);
      idle(HOLD + 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/st_decoder.md
# st_decoder

Issue stage directly upstream of the stack controller. It accepts 16-bit Thumb stack-class instructions over a valid/ready handshake and decodes them into the controller's one-hot `op_sel`, `RL`, `Rd0`, `Rd1` and scaled-offset fields. Each decoded operation is held stable for exactly as many cycles as the controller's sequencing needs: 1 cycle for single-cycle ops, 11 cycles for PUSH/POP. Unsupported encodings are flagged and retired as NOP.

## Interface
Parameters:
- `MULTI_CYCLES`, default 11: hold length for PUSH/POP, covering the idle, 9 register-position and terminal controller states.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `instr` in 16: Thumb instruction.
- `instr_valid` in 1: `instr` is valid.
- `instr_ready` out 1: decoder accepts `instr` on this edge.
- `op_sel` out 8: one-hot op to the controller. Encodings: NOP 0x00, PUSH 0x01, POP 0x02, ADDSP 0x04, SUBSP 0x08, MOVSP 0x10, ADDS 0x20, LDRSP 0x40, STRSP 0x80.
- `RL` out 9: register list. Bit 8 is LR for PUSH, PC for POP.
- `Rd0` out 3: destination register for MOVSP.
- `Rd1` out 3: Rd field for ADDS, LDRSP and STRSP.
- `offset` out 16: zero-extended immediate × 4.
- `busy` out 1: an op is currently presented on `op_sel`.
- `illegal` out 1: one-cycle pulse for an accepted unsupported encoding.

## Operation
Decode rules (x = don't care):
- `1011_010R_llll_llll` → PUSH, `RL={R,l}`.
- `1011_110R_llll_llll` → POP, `RL={R,l}`.
- `1011_0000_0iii_iiii` → ADDSP, `offset=imm7<<2`.
- `1011_0000_1iii_iiii` → SUBSP, `offset=imm7<<2`.
- `0100_0110_0110_1ddd` → MOVSP, `Rd0=d`.
- `1010_1ddd_iiii_iiii` → ADDS, `Rd1=d`, `offset=imm8<<2`.
- `1001_1ddd_iiii_iiii` → LDRSP, `Rd1=d`, `offset=imm8<<2`.
- `1001_0ddd_iiii_iiii` → STRSP, `Rd1=d`, `offset=imm8<<2`.
- Anything else, including PUSH/POP with `RL==0`: accepted, `op_sel=NOP`, `illegal` pulses in the presentation cycle.
- Any field not used by the decoded op is driven to 0.

State machine: IDLE, SINGLE, MULTI. A 4-bit counter `cnt` tracks position within MULTI.
- IDLE: `instr_ready=1`. On accept, decode into the output registers. Go to MULTI with `cnt=MULTI_CYCLES-1` for PUSH/POP, otherwise go to SINGLE.
- SINGLE: the op is presented for 1 cycle; `instr_ready=1`. On accept, reload (back-to-back). With no accept, go to IDLE with outputs set to NOP/0.
- MULTI: the op is held unchanged. `cnt` decrements each cycle. `instr_ready=1` only when `cnt==0`. At `cnt==0`, either accept the next instruction (back-to-back) or go to IDLE.
- `busy=1` in SINGLE and MULTI.
- `instr_ready` is combinational from state/`cnt` only; it never depends on `instr_valid`.

Reset: all outputs 0 (`op_sel=NOP`, `RL=0`, `Rd0=Rd1=0`, `offset=0`, `busy=0`, `illegal=0`), state IDLE, `cnt=0`. `instr_ready=1` once reset deasserts. Reset asserted mid-MULTI abandons the op immediately; no partial hold resumes.

## Timing
- Latency: `instr` accepted at edge N appears on `op_sel` and the fields from edge N to N+1, i.e. one registered stage.
- Hold: PUSH/POP are presented for exactly 11 consecutive cycles; all other ops for exactly 1.
- Throughput: single-cycle ops, 1 per cycle. PUSH/POP, 1 per 11 cycles. No bubble between consecutive ops when `instr_valid` is held.
- `instr_valid` low while `instr_ready=1`: no accept. Outputs go to NOP the next cycle unless still mid-MULTI.
- `instr` and `instr_valid` are ignored while `instr_ready=0`. The upstream side must hold them stable.

## Test plan
- Reset mid-PUSH: assert `reset` at the 5th cycle of a PUSH → all outputs are 0 in the same cycle, `instr_ready=1` after release, and the next op presents normally.
- PUSH `0xB5F0` then POP `0xBDF0`, `instr_valid` held high:
  - PUSH: `op_sel=0x01`, `RL=0x1F0` for 11 cycles, `instr_ready` high only on the 11th.
  - POP: `op_sel=0x02`, `RL=0x1F0` for the next 11 cycles, no gap.
- Back-to-back singles:
  - `0xB004` → ADDSP, `offset=16`.
  - `0xB084` → SUBSP, `offset=16`.
  - `0x466A` → MOVSP, `Rd0=2`.
  - `0xAB05` → ADDS, `Rd1=3`, `offset=20`.
  - Each is presented exactly 1 cycle, on consecutive cycles.
- Load/store: `0x9CFF` → LDRSP, `Rd1=4`, `offset=0x3FC`. `0x9001` → STRSP, `Rd1=0`, `offset=4`.
- Illegal: `0x0000` and `0xB400` (empty RL) → `op_sel=0x00`, `illegal` pulses 1 cycle each, `busy` high for 1 cycle.
- Stall: `instr_valid` drops after an ADDSP → next cycle `op_sel=0x00`, `busy=0`. On reassert, latency is 1 cycle.
